// File: rtl/pulse_window_ctrl.sv
// Multi-channel pulse-to-level converter: start/end strobes become a held level,
// the window length is reported on close, and windows can be force-closed by timeout.
module pulse_window_ctrl #(
  parameter int NCH       = 4,
  parameter int CNT_W     = 16,
  parameter int FAST_PATH = 1,
  parameter int TIMEOUT   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           start_pulse,
  input  logic [NCH-1:0]           end_pulse,
  input  logic [NCH-1:0]           abort,
  output logic [NCH-1:0]           level,
  output logic [NCH-1:0]           dur_valid,
  output logic [NCH*CNT_W-1:0]     dur_data,
  output logic [NCH-1:0]           timeout_flag,
  output logic [$clog2(NCH+1)-1:0] active_count
);
  localparam int               AC_W    = $clog2(NCH+1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam bit               TO_EN   = (TIMEOUT != 0);

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t           r_state     [NCH];
  state_t           w_state_nxt [NCH];
  logic [CNT_W-1:0] r_cnt       [NCH];
  logic [CNT_W-1:0] w_cnt_nxt   [NCH];

  logic [NCH-1:0]       w_report;
  logic [NCH-1:0]       w_to_close;
  logic [NCH-1:0]       w_to_hit;
  logic [NCH-1:0]       w_level_fast;
  logic [NCH-1:0]       w_level_reg;
  logic [AC_W-1:0]      w_active_cnt;
  logic [NCH-1:0]       r_dur_valid;
  logic [NCH-1:0]       r_timeout_flag;
  logic [NCH*CNT_W-1:0] r_dur_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // Close priority in ACTIVE: abort, then end, then timeout, else count on.
  always_comb begin
    w_report   = '0;
    w_to_close = '0;
    w_to_hit   = '0;
    for (int i = 0; i < NCH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_to_hit[i]    = TO_EN && (r_cnt[i] == TO_VAL);
      case (r_state[i])
        S_IDLE: begin
          if (start_pulse[i] && !abort[i]) begin
            w_state_nxt[i] = S_ACTIVE;
            w_cnt_nxt[i]   = CNT_ONE;
          end
        end
        S_ACTIVE: begin
          if (abort[i]) begin
            w_state_nxt[i] = S_IDLE;
            w_cnt_nxt[i]   = '0;
          end else if (end_pulse[i]) begin
            w_state_nxt[i] = S_IDLE;
            w_cnt_nxt[i]   = '0;
            w_report[i]    = 1'b1;
          end else if (w_to_hit[i]) begin
            w_state_nxt[i] = S_IDLE;
            w_cnt_nxt[i]   = '0;
            w_report[i]    = 1'b1;
            w_to_close[i]  = 1'b1;
          end else if (r_cnt[i] != CNT_MAX) begin
            w_cnt_nxt[i]   = r_cnt[i] + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt[i] = S_IDLE;
          w_cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  // Fast level is gated by rst_n so it stays low while reset is held.
  always_comb begin
    w_level_fast = '0;
    w_level_reg  = '0;
    w_active_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      w_level_reg[i]  = (r_state[i] == S_ACTIVE);
      w_level_fast[i] = rst_n &&
        (((r_state[i] == S_IDLE) && start_pulse[i] && !abort[i]) ||
         ((r_state[i] == S_ACTIVE) && !abort[i] && !end_pulse[i] && !w_to_hit[i]));
      w_active_cnt    = w_active_cnt + AC_W'(w_level_reg[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dur_valid    <= '0;
      r_timeout_flag <= '0;
      r_dur_data     <= '0;
    end else begin
      r_dur_valid    <= w_report;
      r_timeout_flag <= w_to_close;
      for (int i = 0; i < NCH; i++) begin
        if (w_report[i]) begin
          r_dur_data[i*CNT_W +: CNT_W] <= w_to_close[i] ? TO_VAL : r_cnt[i];
        end
      end
    end
  end

  assign level        = (FAST_PATH != 0) ? w_level_fast : w_level_reg;
  assign dur_valid    = r_dur_valid;
  assign timeout_flag = r_timeout_flag;
  assign dur_data     = r_dur_data;
  assign active_count = w_active_cnt;

endmodule

// File: tb/tb_pulse_window_ctrl.sv
// Directed bench for pulse_window_ctrl: four configurations share one stimulus bus
// and each scenario task checks the instance whose parameters it targets.
module tb_pulse_window_ctrl;
  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] start = '0;
  logic [3:0] endp  = '0;
  logic [3:0] abrt  = '0;

  logic [3:0]  lv_f, dv_f, tf_f, lv_s, dv_s, tf_s, lv_t, dv_t, tf_t, lv_x, dv_x, tf_x;
  logic [63:0] dd_f, dd_s, dd_t;
  logic [15:0] dd_x;
  logic [2:0]  ac_f, ac_s, ac_t, ac_x;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pulse_window_ctrl #(.NCH(4), .CNT_W(16), .FAST_PATH(1), .TIMEOUT(0)) u_fast (
    .clk(clk), .rst_n(rst_n), .start_pulse(start), .end_pulse(endp), .abort(abrt),
    .level(lv_f), .dur_valid(dv_f), .dur_data(dd_f), .timeout_flag(tf_f), .active_count(ac_f));
  pulse_window_ctrl #(.NCH(4), .CNT_W(16), .FAST_PATH(0), .TIMEOUT(0)) u_slow (
    .clk(clk), .rst_n(rst_n), .start_pulse(start), .end_pulse(endp), .abort(abrt),
    .level(lv_s), .dur_valid(dv_s), .dur_data(dd_s), .timeout_flag(tf_s), .active_count(ac_s));
  pulse_window_ctrl #(.NCH(4), .CNT_W(16), .FAST_PATH(1), .TIMEOUT(8)) u_to (
    .clk(clk), .rst_n(rst_n), .start_pulse(start), .end_pulse(endp), .abort(abrt),
    .level(lv_t), .dur_valid(dv_t), .dur_data(dd_t), .timeout_flag(tf_t), .active_count(ac_t));
  pulse_window_ctrl #(.NCH(4), .CNT_W(4), .FAST_PATH(1), .TIMEOUT(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .start_pulse(start), .end_pulse(endp), .abort(abrt),
    .level(lv_x), .dur_valid(dv_x), .dur_data(dd_x), .timeout_flag(tf_x), .active_count(ac_x));

  // Advance to just after the next rising edge and drop all strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    start = '0;
    endp  = '0;
    abrt  = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    start = '0; endp = '0; abrt = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({lv_f, lv_s, lv_t, lv_x} !== 16'h0) begin
      errors++; $display("FAIL reset_level got=%h exp=0", {lv_f, lv_s, lv_t, lv_x});
    end
    checks++;
    if ({dv_f, dv_s, dv_t, dv_x, tf_f, tf_s, tf_t, tf_x} !== 32'h0) begin
      errors++; $display("FAIL reset_strobes got=%h exp=0", {dv_f, dv_s, dv_t, dv_x, tf_f, tf_s, tf_t, tf_x});
    end
    checks++;
    if ({dd_f, dd_s, dd_t, dd_x} !== 208'h0) begin
      errors++; $display("FAIL reset_dur_data got=%h exp=0", {dd_f, dd_s, dd_t, dd_x});
    end
    checks++;
    if ({ac_f, ac_s, ac_t, ac_x} !== 12'h0) begin
      errors++; $display("FAIL reset_active_count got=%h exp=0", {ac_f, ac_s, ac_t, ac_x});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic_window();
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      tick();
      start[0] = (c == 10);
      endp[0]  = (c == 15);
      @(negedge clk);
      checks++;
      if (lv_f[0] !== (c >= 10 && c <= 14)) begin
        errors++; $display("FAIL basic_fast_level c=%0d got=%b", c, lv_f[0]);
      end
      checks++;
      if (lv_s[0] !== (c >= 11 && c <= 15)) begin
        errors++; $display("FAIL basic_reg_level c=%0d got=%b", c, lv_s[0]);
      end
      checks++;
      if (ac_f !== ((c >= 11 && c <= 15) ? 3'd1 : 3'd0)) begin
        errors++; $display("FAIL basic_active_count c=%0d got=%0d", c, ac_f);
      end
      checks++;
      if ({dv_f[0], dv_s[0]} !== ((c == 16) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL basic_dur_valid c=%0d got=%b%b", c, dv_f[0], dv_s[0]);
      end
      if (c == 16) begin
        checks++;
        if (dd_f[15:0] !== 16'd5 || dd_s[15:0] !== 16'd5) begin
          errors++; $display("FAIL basic_dur_data got=%0d/%0d exp=5", dd_f[15:0], dd_s[15:0]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int c = 0; c <= 11; c++) begin
        tick();
        start[2] = (c == 0);
        endp[2]  = (r == 1 && c == 8);
        @(negedge clk);
        checks++;
        if (lv_t[2] !== (c <= 7)) begin
          errors++; $display("FAIL to_level r=%0d c=%0d got=%b", r, c, lv_t[2]);
        end
        checks++;
        if (dv_t[2] !== (c == 9)) begin
          errors++; $display("FAIL to_dur_valid r=%0d c=%0d got=%b", r, c, dv_t[2]);
        end
        checks++;
        if (tf_t[2] !== (r == 0 && c == 9)) begin
          errors++; $display("FAIL to_flag r=%0d c=%0d got=%b", r, c, tf_t[2]);
        end
        if (c == 9) begin
          checks++;
          if (dd_t[32 +: 16] !== 16'd8) begin
            errors++; $display("FAIL to_dur_data r=%0d got=%0d exp=8", r, dd_t[32 +: 16]);
          end
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic exp_lv;
    logic exp_ac;
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      tick();
      start[1] = (c == 0 || c == 3 || c == 7 || c == 12 || c == 14);
      endp[1]  = (c == 0 || c == 5 || c == 10 || c == 14);
      abrt[1]  = (c == 10);
      @(negedge clk);
      exp_lv = (c <= 4) || (c >= 7 && c <= 9) || (c == 12 || c == 13);
      exp_ac = (c >= 1 && c <= 5) || (c >= 8 && c <= 10) || (c == 13 || c == 14);
      checks++;
      if (lv_f[1] !== exp_lv) begin
        errors++; $display("FAIL sim_level c=%0d got=%b exp=%b", c, lv_f[1], exp_lv);
      end
      checks++;
      if (ac_f !== {2'b00, exp_ac}) begin
        errors++; $display("FAIL sim_active_count c=%0d got=%0d exp=%0d", c, ac_f, exp_ac);
      end
      checks++;
      if (dv_f[1] !== (c == 6 || c == 15)) begin
        errors++; $display("FAIL sim_dur_valid c=%0d got=%b", c, dv_f[1]);
      end
      if (c == 6 || c == 11) begin
        checks++;
        if (dd_f[16 +: 16] !== 16'd5) begin
          errors++; $display("FAIL sim_dur_data c=%0d got=%0d exp=5", c, dd_f[16 +: 16]);
        end
      end
      if (c == 15) begin
        checks++;
        if (dd_f[16 +: 16] !== 16'd2) begin
          errors++; $display("FAIL sim_no_rearm_dur c=%0d got=%0d exp=2", c, dd_f[16 +: 16]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      tick();
      start[0] = (c == 0);
      endp[0]  = (c == 20);
      @(negedge clk);
      checks++;
      if (lv_x[0] !== (c <= 19)) begin
        errors++; $display("FAIL sat_level c=%0d got=%b", c, lv_x[0]);
      end
      checks++;
      if (dv_x[0] !== (c == 21)) begin
        errors++; $display("FAIL sat_dur_valid c=%0d got=%b", c, dv_x[0]);
      end
      if (c == 21) begin
        checks++;
        if (dd_x[3:0] !== 4'd15) begin
          errors++; $display("FAIL sat_dur_data got=%0d exp=15", dd_x[3:0]);
        end
        checks++;
        if (dd_f[15:0] !== 16'd20) begin
          errors++; $display("FAIL wide_dur_data got=%0d exp=20", dd_f[15:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_window();
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      tick();
      start[3] = (c == 0);
      @(negedge clk);
    end
    checks++;
    if (lv_s[3] !== 1'b1 || ac_f !== 3'd1) begin
      errors++; $display("FAIL rst_pre_active got=%b/%0d exp=1/1", lv_s[3], ac_f);
    end
    tick();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({lv_f[3], lv_s[3]} !== 2'b00 || ac_f !== 3'd0 || ac_s !== 3'd0) begin
      errors++; $display("FAIL rst_async_drop got=%b%b/%0d/%0d exp=00/0/0", lv_f[3], lv_s[3], ac_f, ac_s);
    end
    start[3] = 1'b1;
    @(negedge clk);
    checks++;
    if (lv_f[3] !== 1'b0) begin
      errors++; $display("FAIL rst_fast_level_gated got=%b exp=0", lv_f[3]);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({dv_f[3], dv_s[3]} !== 2'b00) begin
        errors++; $display("FAIL rst_no_dur_valid k=%0d got=%b%b", k, dv_f[3], dv_s[3]);
      end
    end
    tick();
    rst_n    = 1'b1;
    start[3] = 1'b1;
    @(negedge clk);
    checks++;
    if (lv_f[3] !== 1'b1 || dv_f[3] !== 1'b0) begin
      errors++; $display("FAIL rst_release_start got=%b/%b exp=1/0", lv_f[3], dv_f[3]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (lv_s[3] !== 1'b1 || ac_f !== 3'd1 || dv_f[3] !== 1'b0) begin
      errors++; $display("FAIL rst_first_edge_accept got=%b/%0d/%b exp=1/1/0", lv_s[3], ac_f, dv_f[3]);
    end
    tick();
    endp[3] = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (dv_f[3] !== 1'b1 || dd_f[48 +: 16] !== 16'd2) begin
      errors++; $display("FAIL rst_new_window got=%b/%0d exp=1/2", dv_f[3], dd_f[48 +: 16]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_window();
    test_timeout();
    test_simultaneous();
    test_saturation();
    test_reset_mid_window();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
